mem_wb_pipe: RTL and testbench
==============================

MEM_WB_PIPE -- requirements
Module: mem_wb_pipe

Interface
REQ-001 Parameter XLEN, default 32, datapath width of PC/ALU/memory fields.
REQ-002 Parameter RADDR_W, default 5, destination register address width.
REQ-003 Parameter SRC_W, default 2, write-back source select width.
REQ-004 clk  in  1  single clock; all state updates on posedge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 in_valid  in  1  MEM stage presents a valid instruction.
REQ-007 in_ready  out  1  stage accepts input this cycle.
REQ-008 flush  in  1  discard all held instructions.
REQ-009 incrementPCIn, ALUResIn, DMDataRdIn  in  XLEN each  MEM payload.
REQ-010 rdIn  in  RADDR_W  destination register.
REQ-011 ru_data_srcIn  in  SRC_W  write-back source select.
REQ-012 ru_wrIn  in  1  register-file write enable.
REQ-013 out_valid  out  1  WB payload valid.
REQ-014 out_ready  in  1  WB consumes payload this cycle.
REQ-015 incrementPCOut, ALUResOut, DMDataRdOut, rdOut, ru_data_srcOut, ru_wrOut  out  matching widths  registered payload of head entry.
REQ-016 wb_data  out  XLEN  selected write-back value.
REQ-017 wb_we  out  1  out_valid AND ru_wrOut AND out_ready.
REQ-018 occupancy  out  2  number of held entries (0..2).

Function
REQ-019 Two-entry elastic stage: head register (drives outputs) plus skid register; accept = in_valid AND in_ready; consume = out_valid AND out_ready.
REQ-020 in_ready SHALL be a registered signal equal to NOT skid_valid; no combinational path from out_ready to in_ready.
REQ-021 Head empty, accept: payload to head next cycle; latency one cycle input to output.
REQ-022 Head full, consume and accept same cycle: new payload to head; skid untouched.
REQ-023 Head full, no consume, accept: payload to skid; in_ready low next cycle.
REQ-024 Consume with skid valid: skid moves to head next cycle, skid clears, in_ready high next cycle; simultaneous accept impossible (in_ready low).
REQ-025 Consume, no accept, skid empty: head invalidated; payload registers keep last value.
REQ-026 Held payloads SHALL NOT change while out_valid=1 and out_ready=0.
REQ-027 Order preserved: FIFO, no drop, no duplication.
REQ-028 flush=1: next cycle head and skid invalid, occupancy 0, in_ready 1; same-cycle accept discarded; flush priority over all other events.
REQ-029 wb_data: src 0 -> ALUResOut, 1 -> DMDataRdOut, 2 -> incrementPCOut, any other -> 0; combinational from head.
REQ-030 occupancy = head_valid + skid_valid; never exceeds 2.
REQ-031 ru_wrOut forced 0 whenever out_valid=0.

Reset
REQ-032 rst_n=0 at posedge: head/skid valid 0, all payload outputs 0, occupancy 0, in_ready 1 next cycle.
REQ-033 Reset mid-transfer drops held entries; no output change until first accept after release.
REQ-034 Reset priority over flush and accept.

Verification
REQ-035 Streaming: in_valid=1, out_ready=1, ALUResIn=0x10,0x11,0x12 -> ALUResOut 0x10,0x11,0x12 one cycle later each, occupancy 1, in_ready steady 1.
REQ-036 Backpressure: out_ready=0, push A=0xA, B=0xB -> occupancy 2, in_ready 0, head A held; out_ready=1 -> A, then B next cycle, in_ready 1.
REQ-037 Flush while full: occupancy 2, flush=1 with in_valid=1 -> next cycle out_valid 0, occupancy 0, in_ready 1, accepted word absent.
REQ-038 Write-back select: ALU=0x1, DM=0x2, PC=0x3, src 0/1/2/3 -> wb_data 0x1/0x2/0x3/0x0.
REQ-039 Reset with occupancy 2 -> next cycle all outputs 0, in_ready 1, wb_we 0.
REQ-040 Random in_valid/out_ready 10k cycles -> scoreboard order and count exact, no output change while stalled.

Source files
------------

// File: rtl/mem_wb_pipe_if.sv
// MEM-to-WB handshake bundle: valid/ready pairs, MEM payload in, WB payload and
// write-back controls out. The master side is the producer/consumer pair around the stage.
interface mem_wb_pipe_if #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5,
  parameter int SRC_W   = 2
);
  logic               in_valid;
  logic               in_ready;
  logic [XLEN-1:0]    incrementPCIn;
  logic [XLEN-1:0]    ALUResIn;
  logic [XLEN-1:0]    DMDataRdIn;
  logic [RADDR_W-1:0] rdIn;
  logic [SRC_W-1:0]   ru_data_srcIn;
  logic               ru_wrIn;

  logic               out_valid;
  logic               out_ready;
  logic [XLEN-1:0]    incrementPCOut;
  logic [XLEN-1:0]    ALUResOut;
  logic [XLEN-1:0]    DMDataRdOut;
  logic [RADDR_W-1:0] rdOut;
  logic [SRC_W-1:0]   ru_data_srcOut;
  logic               ru_wrOut;
  logic [XLEN-1:0]    wb_data;
  logic               wb_we;

  modport master (
    output in_valid, incrementPCIn, ALUResIn, DMDataRdIn, rdIn, ru_data_srcIn, ru_wrIn,
    output out_ready,
    input  in_ready, out_valid, incrementPCOut, ALUResOut, DMDataRdOut, rdOut,
    input  ru_data_srcOut, ru_wrOut, wb_data, wb_we
  );

  modport slave (
    input  in_valid, incrementPCIn, ALUResIn, DMDataRdIn, rdIn, ru_data_srcIn, ru_wrIn,
    input  out_ready,
    output in_ready, out_valid, incrementPCOut, ALUResOut, DMDataRdOut, rdOut,
    output ru_data_srcOut, ru_wrOut, wb_data, wb_we
  );
endinterface

// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline register as a two-entry elastic stage (head + skid) so that
// in_ready is a pure flop and never depends combinationally on out_ready.
module mem_wb_pipe #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5,
  parameter int SRC_W   = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  output logic [1:0]     occupancy,
  mem_wb_pipe_if.slave   bus
);

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    alu;
    logic [XLEN-1:0]    dm;
    logic [RADDR_W-1:0] rd;
    logic [SRC_W-1:0]   src;
    logic               we;
  } payload_t;

  payload_t head_q, head_d;
  payload_t skid_q, skid_d;
  logic     head_valid_q, head_valid_d;
  logic     skid_valid_q, skid_valid_d;
  logic     in_ready_q, in_ready_d;

  payload_t in_payload;
  logic     accept;
  logic     consume;

  always_comb begin
    in_payload.pc  = bus.incrementPCIn;
    in_payload.alu = bus.ALUResIn;
    in_payload.dm  = bus.DMDataRdIn;
    in_payload.rd  = bus.rdIn;
    in_payload.src = bus.ru_data_srcIn;
    in_payload.we  = bus.ru_wrIn;
    accept         = bus.in_valid & in_ready_q;
    consume        = head_valid_q & bus.out_ready;
  end

  // Payload registers only load on a transfer; valids alone track occupancy.
  always_comb begin
    head_d       = head_q;
    skid_d       = skid_q;
    head_valid_d = head_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      head_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (consume) begin
      if (skid_valid_q) begin
        head_d       = skid_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        head_d = in_payload;
      end else begin
        head_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (head_valid_q) begin
        skid_d       = in_payload;
        skid_valid_d = 1'b1;
      end else begin
        head_d       = in_payload;
        head_valid_d = 1'b1;
      end
    end
    in_ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q       <= '0;
      skid_q       <= '0;
      head_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      head_q       <= head_d;
      skid_q       <= skid_d;
      head_valid_q <= head_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  always_comb begin
    bus.in_ready       = in_ready_q;
    bus.out_valid      = head_valid_q;
    bus.incrementPCOut = head_q.pc;
    bus.ALUResOut      = head_q.alu;
    bus.DMDataRdOut    = head_q.dm;
    bus.rdOut          = head_q.rd;
    bus.ru_data_srcOut = head_q.src;
    bus.ru_wrOut       = head_q.we & head_valid_q;
    bus.wb_we          = head_valid_q & head_q.we & bus.out_ready;
    occupancy          = 2'(head_valid_q) + 2'(skid_valid_q);
  end

  always_comb begin
    bus.wb_data = '0;
    if (head_q.src == SRC_W'(0))
      bus.wb_data = head_q.alu;
    else if (head_q.src == SRC_W'(1))
      bus.wb_data = head_q.dm;
    else if (head_q.src == SRC_W'(2))
      bus.wb_data = head_q.pc;
  end

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Directed plus random test of mem_wb_pipe against a queue model of the held entries.
module tb_mem_wb_pipe;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] alu;
      logic [31:0] dm;
      logic [4:0]  rd;
      logic [1:0]  src;
      logic        we;
   } pay_t;

   logic       clk;
   logic       rst_n;
   logic       flush;
   logic [1:0] occupancy;

   mem_wb_pipe_if #(.XLEN(32), .RADDR_W(5), .SRC_W(2)) bus ();

   mem_wb_pipe #(.XLEN(32), .RADDR_W(5), .SRC_W(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .occupancy (occupancy),
      .bus       (bus.slave)
   );

   int   checks = 0;
   int   failures = 0;
   pay_t sb[$];
   pay_t lastHead;
   logic modelReady;
   pay_t idle;

   // Free-running clock, 10 time-unit period
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point; every check in the bench goes through here
   task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] wbSelect(input pay_t p);
      case (p.src)
         2'd0:    return p.alu;
         2'd1:    return p.dm;
         2'd2:    return p.pc;
         default: return 32'h0;
      endcase
   endfunction

   function automatic pay_t mkPay(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] dm,
                                  input logic [4:0] rd, input logic [1:0] src, input logic we);
      pay_t p;
      p.pc = pc; p.alu = alu; p.dm = dm; p.rd = rd; p.src = src; p.we = we;
      return p;
   endfunction

   function automatic pay_t randPay();
      return mkPay($urandom, $urandom, $urandom, 5'($urandom), 2'($urandom), 1'($urandom));
   endfunction

   // Compare all DUT outputs against the model, then clock once and update the model
   task automatic applyStimulus(input logic v, input pay_t p, input logic ordy, input logic fl, input logic rst);
      logic accept;
      logic consume;
      logic hv;
      pay_t h;
      pay_t expOut;
      bus.in_valid      = v;
      bus.incrementPCIn = p.pc;
      bus.ALUResIn      = p.alu;
      bus.DMDataRdIn    = p.dm;
      bus.rdIn          = p.rd;
      bus.ru_data_srcIn = p.src;
      bus.ru_wrIn       = p.we;
      bus.out_ready     = ordy;
      flush             = fl;
      rst_n             = ~rst;
      #1;
      hv = (sb.size() > 0);
      h  = hv ? sb[0] : lastHead;
      expOut = h;
      expOut.we = hv & h.we;
      checkOutput("in_ready", 128'(bus.in_ready), 128'(modelReady));
      checkOutput("out_valid", 128'(bus.out_valid), 128'(hv));
      checkOutput("occupancy", 128'(occupancy), 128'(sb.size()));
      checkOutput("payload", 128'({bus.incrementPCOut, bus.ALUResOut, bus.DMDataRdOut, bus.rdOut,
                                   bus.ru_data_srcOut, bus.ru_wrOut}), 128'(expOut));
      checkOutput("wb_we", 128'(bus.wb_we), 128'(hv & h.we & ordy));
      if (hv) checkOutput("wb_data", 128'(bus.wb_data), 128'(wbSelect(h)));
      accept  = v & modelReady;
      consume = hv & ordy;
      @(posedge clk);
      #1;
      if (rst) begin
         sb.delete();
         lastHead = '0;
      end else if (fl) begin
         sb.delete();
      end else begin
         if (consume) void'(sb.pop_front());
         if (accept) sb.push_back(p);
      end
      modelReady = (sb.size() < 2);
      if (sb.size() > 0) lastHead = sb[0];
   endtask

   // Directed scenarios first, then a long random handshake run
   initial begin
      idle = '0;
      rst_n = 1'b0;
      flush = 1'b0;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      bus.incrementPCIn = '0; bus.ALUResIn = '0; bus.DMDataRdIn = '0;
      bus.rdIn = '0; bus.ru_data_srcIn = '0; bus.ru_wrIn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      sb.delete();
      lastHead = '0;
      modelReady = 1'b1;

      $display("[TB] reset state");
      applyStimulus(1'b0, idle, 1'b0, 1'b0, 1'b0);
      checkOutput("reset_wb_data", 128'(bus.wb_data), 128'(0));

      $display("[TB] streaming");
      applyStimulus(1'b1, mkPay(32'h4, 32'h10, 32'h0, 5'd1, 2'd0, 1'b1), 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, mkPay(32'h8, 32'h11, 32'h0, 5'd2, 2'd0, 1'b1), 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, mkPay(32'hC, 32'h12, 32'h0, 5'd3, 2'd0, 1'b1), 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, idle, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, idle, 1'b1, 1'b0, 1'b0);

      $display("[TB] backpressure");
      applyStimulus(1'b1, mkPay(32'h0, 32'hA, 32'h0, 5'd4, 2'd0, 1'b1), 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, mkPay(32'h0, 32'hB, 32'h0, 5'd5, 2'd0, 1'b1), 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, mkPay(32'h0, 32'hC, 32'h0, 5'd6, 2'd0, 1'b1), 1'b0, 1'b0, 1'b0);
      checkOutput("bp_occupancy", 128'(occupancy), 128'(2));
      checkOutput("bp_in_ready", 128'(bus.in_ready), 128'(0));
      checkOutput("bp_head", 128'(bus.ALUResOut), 128'(32'hA));
      applyStimulus(1'b0, idle, 1'b1, 1'b0, 1'b0);
      checkOutput("bp_second", 128'(bus.ALUResOut), 128'(32'hB));
      applyStimulus(1'b0, idle, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, idle, 1'b1, 1'b0, 1'b0);

      $display("[TB] flush while full");
      applyStimulus(1'b1, mkPay(32'h0, 32'h21, 32'h0, 5'd7, 2'd0, 1'b1), 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, mkPay(32'h0, 32'h22, 32'h0, 5'd8, 2'd0, 1'b1), 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, mkPay(32'h0, 32'h23, 32'h0, 5'd9, 2'd0, 1'b1), 1'b0, 1'b1, 1'b0);
      checkOutput("flush_occupancy", 128'(occupancy), 128'(0));
      applyStimulus(1'b0, idle, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, idle, 1'b1, 1'b0, 1'b0);

      $display("[TB] write-back select");
      for (int s = 0; s < 4; s++)
         applyStimulus(1'b1, mkPay(32'h3, 32'h1, 32'h2, 5'(s), 2'(s), 1'b1), 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, idle, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, idle, 1'b0, 1'b0, 1'b0);

      $display("[TB] reset while full");
      applyStimulus(1'b1, mkPay(32'h31, 32'h32, 32'h33, 5'd10, 2'd1, 1'b1), 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, mkPay(32'h41, 32'h42, 32'h43, 5'd11, 2'd2, 1'b1), 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, randPay(), 1'b1, 1'b1, 1'b1);
      checkOutput("rst_wb_data", 128'(bus.wb_data), 128'(0));
      applyStimulus(1'b0, idle, 1'b1, 1'b0, 1'b0);

      $display("[TB] random handshake");
      for (int i = 0; i < 10000; i++)
         applyStimulus(1'($urandom_range(0, 1)), randPay(), 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 99) == 0), 1'b0);
      for (int i = 0; i < 3; i++)
         applyStimulus(1'b0, idle, 1'b1, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
